// File: rtl/color_seq_gen_if.sv
// Request/colour handshake between the game FSM (master) and the colour source (slave).
interface color_seq_gen_if;
  logic       pulseSeq;
  logic [3:0] colorSeq;
  logic       colorPronto;
  logic [5:0] genCount;

  modport master (
    output pulseSeq,
    input  colorSeq,
    input  colorPronto,
    input  genCount
  );

  modport slave (
    input  pulseSeq,
    output colorSeq,
    output colorPronto,
    output genCount
  );
endinterface

// File: rtl/color_seq_gen.sv
// Pseudo-random colour source: a free-running 16-bit LFSR is sampled on each request, limited
// against long runs of one colour, and presented with a fixed-width registered pronto pulse.
module color_seq_gen #(
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned PRONTO_CYCLES = 2,
  parameter int unsigned MAX_REPEAT    = 2
) (
  input logic             clock,
  input logic             reset,
  color_seq_gen_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StGen, StReady, StRelease} state_e;

  localparam logic [3:0] ProntoLast = 4'(PRONTO_CYCLES - 1);
  localparam logic [2:0] MaxRep     = 3'(MAX_REPEAT);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  last_idx_q, last_idx_d;
  logic [2:0]  rep_cnt_q, rep_cnt_d;
  logic [3:0]  dwn_q, dwn_d;
  logic [3:0]  color_q, color_d;
  logic        pronto_q, pronto_d;
  logic [5:0]  gen_cnt_q, gen_cnt_d;
  logic [1:0]  cand_idx, gen_idx;
  logic        fb;

  function automatic logic [3:0] enc(input logic [1:0] idx);
    return {2'b00, idx} + 4'd1;
  endfunction

  // LFSR advance every clock; a zero state (unreachable in practice) reloads the seed.
  always_comb begin
    fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = (lfsr_q == 16'h0000) ? SEED : {lfsr_q[14:0], fb};
  end

  // Repeat limiter: bump the candidate when it would extend a run already at the limit.
  always_comb begin
    cand_idx = lfsr_q[1:0];
    gen_idx  = cand_idx;
    if ((cand_idx == last_idx_q) && (rep_cnt_q == MaxRep)) begin
      gen_idx = cand_idx + 2'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; RELEASE waits for the request to drop so a held level yields one colour.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.pulseSeq) state_d = StGen;
      StGen:     state_d = StReady;
      StReady:   if (dwn_q == 4'd0) state_d = StRelease;
      StRelease: if (!bus.pulseSeq) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath next values; pronto and genCount are registered one stage
  // behind READY, so genCount steps on the same edge that pronto falls.
  always_comb begin
    color_d    = color_q;
    last_idx_d = last_idx_q;
    rep_cnt_d  = rep_cnt_q;
    dwn_d      = dwn_q;
    gen_cnt_d  = gen_cnt_q;
    pronto_d   = (state_q == StReady);
    unique case (state_q)
      StGen: begin
        color_d    = enc(gen_idx);
        last_idx_d = gen_idx;
        rep_cnt_d  = (gen_idx == last_idx_q) ? rep_cnt_q + 3'd1 : 3'd1;
        dwn_d      = ProntoLast;
      end
      StReady: begin
        if (dwn_q != 4'd0) dwn_d = dwn_q - 4'd1;
      end
      default: ;
    endcase
    if (pronto_q && !pronto_d) begin
      gen_cnt_d = gen_cnt_q + 6'd1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q     <= SEED;
      last_idx_q <= 2'd0;
      rep_cnt_q  <= 3'd0;
      dwn_q      <= 4'd0;
      color_q    <= 4'b0000;
      pronto_q   <= 1'b0;
      gen_cnt_q  <= 6'd0;
    end else begin
      lfsr_q     <= lfsr_d;
      last_idx_q <= last_idx_d;
      rep_cnt_q  <= rep_cnt_d;
      dwn_q      <= dwn_d;
      color_q    <= color_d;
      pronto_q   <= pronto_d;
      gen_cnt_q  <= gen_cnt_d;
    end
  end

  assign bus.colorSeq    = color_q;
  assign bus.colorPronto = pronto_q;
  assign bus.genCount    = gen_cnt_q;

endmodule

// File: tb/tb_color_seq_gen.sv
// Bench for color_seq_gen: two instances (MAX_REPEAT 2 and 1) share one request stream;
// expected colours come from a spec-level LFSR/limiter model through per-instance queues.
module tb_color_seq_gen;

  localparam int P = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic [3:0] code;
    logic [5:0] cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic pulse;

  always #5 clock = ~clock;

  color_seq_gen_if bus0 ();
  color_seq_gen_if bus1 ();
  assign bus0.pulseSeq = pulse;
  assign bus1.pulseSeq = pulse;

  color_seq_gen #(.SEED(SEED), .PRONTO_CYCLES(P), .MAX_REPEAT(2)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  color_seq_gen #(.SEED(SEED), .PRONTO_CYCLES(P), .MAX_REPEAT(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: spec LFSR stepped once per clock, plus per-instance colour history.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  logic [15:0] lfsr_m;
  always @(posedge clock or posedge reset) begin
    if (reset) lfsr_m <= SEED;
    else       lfsr_m <= lfsr_step(lfsr_m);
  end

  exp_t q0[$];
  exp_t q1[$];
  int m_last[2];
  int m_run[2];
  int m_count[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 0; m_run[k] = 0; m_count[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic predict(input int cand);
    int idx;
    int lim;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 2 : 1;
      idx = cand;
      if (idx == m_last[k] && m_run[k] == lim) idx = (idx + 1) % 4;
      m_run[k]   = (idx == m_last[k]) ? m_run[k] + 1 : 1;
      m_last[k]  = idx;
      m_count[k] = (m_count[k] + 1) % 64;
      e.code = 4'(idx + 1);
      e.cnt  = 6'(m_count[k]);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Monitor state.
  logic       prev_p[2];
  int         width[2];
  int         pulses[2];
  logic [3:0] cur_code[2];
  logic [5:0] exp_cnt[2];
  logic [3:0] h1[2];
  logic [3:0] h2[2];
  int         nh[2];
  logic [3:0] seen[2];

  task automatic mon_step(input int k, input logic [3:0] c, input logic p, input logic [5:0] g);
    exp_t e;
    int   sz;
    if (p && !prev_p[k]) begin
      pulses[k]++;
      sz = (k == 0) ? q0.size() : q1.size();
      check($sformatf("pulse_expected%0d", k), int'(sz > 0), 1);
      if (sz > 0) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("color%0d", k), c, e.code);
        exp_cnt[k] = e.cnt;
      end
      cur_code[k] = c;
      width[k]    = 1;
      if (k == 1 && nh[k] >= 1) check("no_repeat_max1", int'(c != h1[k]), 1);
      if (k == 0 && nh[k] >= 2) check("no_triple_max2", int'(c == h1[k] && c == h2[k]), 0);
      h2[k] = h1[k];
      h1[k] = c;
      nh[k]++;
      if (c >= 4'd1 && c <= 4'd4) seen[k][c - 4'd1] = 1'b1;
    end else if (p && prev_p[k]) begin
      width[k]++;
      check($sformatf("color_stable%0d", k), c, cur_code[k]);
    end else if (!p && prev_p[k]) begin
      check($sformatf("pronto_width%0d", k), width[k], P);
      check($sformatf("gen_count%0d", k), g, exp_cnt[k]);
      check($sformatf("color_hold%0d", k), c, cur_code[k]);
    end
    prev_p[k] = p;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      prev_p[k] = 1'b0; pulses[k] = 0; nh[k] = 0; seen[k] = 4'h0; width[k] = 0;
      cur_code[k] = 4'h0; exp_cnt[k] = 6'h0; h1[k] = 4'h0; h2[k] = 4'h0;
    end
    forever begin
      @(negedge clock);
      if (reset) begin
        for (int k = 0; k < 2; k++) begin
          prev_p[k] = 1'b0; nh[k] = 0;
        end
      end else begin
        mon_step(0, bus0.colorSeq, bus0.colorPronto, bus0.genCount);
        mon_step(1, bus1.colorSeq, bus1.colorPronto, bus1.genCount);
      end
    end
  end

  // Stimulus helpers; each is entered on a negedge with the DUTs idle.
  task automatic check_zero_outputs(input string tag);
    check({tag, "_colorSeq"}, bus0.colorSeq, 0);
    check({tag, "_colorPronto"}, bus0.colorPronto, 0);
    check({tag, "_genCount"}, bus0.genCount, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    pulse = 1'b0;
    model_reset();
    repeat (n) begin
      @(negedge clock);
      check_zero_outputs("in_reset");
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check_zero_outputs("after_reset");
    end
  endtask

  task automatic raise();
    logic [15:0] nxt;
    nxt = lfsr_step(lfsr_m);
    predict(int'(nxt[1:0]));
    pulse = 1'b1;
  endtask

  task automatic timed_request();
    raise();
    for (int j = 0; j <= P + 2; j++) begin
      @(negedge clock);
      check($sformatf("pronto_timing_%0d", j), bus0.colorPronto, int'(j >= 2 && j < 2 + P));
      if (j == 2) pulse = 1'b0;
    end
  endtask

  task automatic request(input int hold_extra);
    int n;
    raise();
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus0.colorPronto && n < 10);
    check("pronto_rise", bus0.colorPronto, 1);
    repeat (hold_extra) @(negedge clock);
    pulse = 1'b0;
    @(negedge clock);
    n = 0;
    while (bus0.colorPronto && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("pronto_fall", bus0.colorPronto, 0);
  endtask

  initial begin
    int p0;
    int since;
    reset = 1'b0;
    pulse = 1'b0;
    #2;
    do_reset(3);
    repeat (4) @(negedge clock);

    // Single request with exact edge timing.
    timed_request();
    check("gen_count_single", bus0.genCount, 1);

    // Held request: one pulse only until the request drops.
    do_reset(2);
    p0 = pulses[0];
    request(18);
    check("held_one_pulse", pulses[0] - p0, 1);
    check("held_gen_count", bus0.genCount, 1);
    request(0);
    check("held_second_pulse", pulses[0] - p0, 2);
    check("held_gen_count2", bus0.genCount, 2);

    // Reset during the first READY cycle clears outputs without waiting for a clock edge.
    raise();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset_colorSeq", bus0.colorSeq, 0);
    check("midreset_colorPronto", bus0.colorPronto, 0);
    check("midreset_genCount", bus0.genCount, 0);
    check("midreset_colorSeq1", bus1.colorSeq, 0);
    @(negedge clock);
    do_reset(2);
    timed_request();
    check("gen_count_post_reset", bus0.genCount, 1);

    // Randomised stream: limiter, coverage of all codes and genCount wrap.
    do_reset(2);
    since = 0;
    for (int r = 0; r < 200; r++) begin
      request(($urandom % 4 == 0) ? int'($urandom_range(1, 5)) : 0);
      since++;
      check((since % 64 == 0) ? "gen_count_wrap" : "gen_count_running",
            bus0.genCount, since % 64);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (4) @(negedge clock);

    check("all_codes_max2", seen[0], 4'hF);
    check("all_codes_max1", seen[1], 4'hF);
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
